// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared constants and mode encoding for the clock divider
package clk_div_pkg;

    localparam int DEF_WIDTH = 17;
    localparam int DEF_DIV   = 100000;

    typedef enum logic {
        MODE_TOGGLE = 1'b0,
        MODE_PULSE  = 1'b1
    } mode_e;

endpackage

// File: rtl/clk_div_chan.sv
// rtl/clk_div_chan.sv - one divider channel: counter, active/shadow config, outputs
//
// Ports:
//   clk, rst        system clock, asynchronous active-low reset
//   en              channel enable; low holds the counter and outputs at 0
//   cfg_we          write strobe for the shadow divisor/mode (only while not pending)
//   cfg_div         new divisor
//   cfg_mode        new mode (0 toggle, 1 pulse)
//   pending         shadow config waiting for its apply point
//   clk_div         divided output
//   tick            one-cycle strobe after each terminal count
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int DEFAULT_DIV = DEF_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_we,
    input  logic [WIDTH-1:0] cfg_div,
    input  logic             cfg_mode,
    output logic             pending,
    output logic             clk_div,
    output logic             tick
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] sdiv_q;
    mode_e            mode_q;
    mode_e            smode_q;
    logic             pending_q;
    logic             clk_div_q;
    logic             tick_q;
    logic             tc;

    assign tc = en && (count_q == div_q - WIDTH'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q   <= '0;
            div_q     <= WIDTH'(DEFAULT_DIV);
            sdiv_q    <= WIDTH'(DEFAULT_DIV);
            mode_q    <= MODE_TOGGLE;
            smode_q   <= MODE_TOGGLE;
            pending_q <= 1'b0;
            clk_div_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            if (!en) begin
                count_q   <= '0;
                clk_div_q <= 1'b0;
                tick_q    <= 1'b0;
                // A stopped channel has no terminal count to wait for.
                if (pending_q) begin
                    div_q     <= sdiv_q;
                    mode_q    <= smode_q;
                    pending_q <= 1'b0;
                end
            end else begin
                tick_q <= tc;
                if (tc) begin
                    count_q <= '0;
                    if (pending_q) begin
                        // Switch over at the period boundary so no runt cycle appears.
                        div_q     <= sdiv_q;
                        mode_q    <= smode_q;
                        pending_q <= 1'b0;
                        clk_div_q <= 1'b0;
                    end else if (mode_q == MODE_TOGGLE) begin
                        clk_div_q <= ~clk_div_q;
                    end else begin
                        clk_div_q <= 1'b1;
                    end
                end else begin
                    count_q <= count_q + WIDTH'(1);
                    if (mode_q == MODE_PULSE) begin
                        clk_div_q <= 1'b0;
                    end
                end
            end
            // cfg_we is only raised while pending_q is clear, so it never races the apply.
            if (cfg_we) begin
                sdiv_q    <= cfg_div;
                smode_q   <= mode_e'(cfg_mode);
                pending_q <= 1'b1;
            end
        end
    end

    assign pending = pending_q;
    assign clk_div = clk_div_q;
    assign tick    = tick_q;

endmodule

// File: rtl/clk_divider_multi.sv
// rtl/clk_divider_multi.sv - multi-channel programmable clock divider / tick generator
//
// Ports:
//   clk, rst        system clock, asynchronous active-low reset
//   en              per-channel enable
//   cfg_valid/ready config handshake; ready is low while the target channel is pending
//   cfg_chan        target channel
//   cfg_div         new divisor (0 is rejected)
//   cfg_mode        0 toggle, 1 pulse
//   cfg_err         one-cycle flag after a rejected config
//   clk_div, tick   per-channel divided output and terminal-count strobe
module clk_divider_multi
    import clk_div_pkg::*;
#(
    parameter int  CHANNELS    = 4,
    parameter int  WIDTH       = DEF_WIDTH,
    parameter int  DEFAULT_DIV = DEF_DIV,
    localparam int CW          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] en,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CW-1:0]       cfg_chan,
    input  logic [WIDTH-1:0]    cfg_div,
    input  logic                cfg_mode,
    output logic                cfg_err,
    output logic [CHANNELS-1:0] clk_div,
    output logic [CHANNELS-1:0] tick
);

    logic [CHANNELS-1:0] pending;
    logic [CHANNELS-1:0] cfg_we;
    logic [2**CW-1:0]    pending_pad;
    logic                chan_ok;
    logic                cfg_fire;
    logic                cfg_bad;
    logic                cfg_err_q;

    // Pad to the full index range so an out-of-range channel reads as not pending.
    always_comb begin
        pending_pad                 = '0;
        pending_pad[CHANNELS-1:0]   = pending;
    end

    assign chan_ok   = int'(cfg_chan) < CHANNELS;
    assign cfg_ready = !pending_pad[cfg_chan];
    assign cfg_fire  = cfg_valid && cfg_ready;
    assign cfg_bad   = (cfg_div == '0) || !chan_ok;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_fire && cfg_bad;
        end
    end

    assign cfg_err = cfg_err_q;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        assign cfg_we[i] = cfg_fire && !cfg_bad && (int'(cfg_chan) == i);

        clk_div_chan #(
            .WIDTH       (WIDTH),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .en       (en[i]),
            .cfg_we   (cfg_we[i]),
            .cfg_div  (cfg_div),
            .cfg_mode (cfg_mode),
            .pending  (pending[i]),
            .clk_div  (clk_div[i]),
            .tick     (tick[i])
        );
    end

endmodule

// File: tb/tb_clk_divider_multi.sv
// tb/tb_clk_divider_multi.sv - directed self-checking bench for clk_divider_multi
module tb_clk_divider_multi;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  en = '0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [1:0]  cfg_chan = '0;
    logic [16:0] cfg_div = '0;
    logic        cfg_mode = 1'b0;
    logic        cfg_err;
    logic [3:0]  clk_div;
    logic [3:0]  tick;

    logic [2:0]  en3 = '0;
    logic        cfg_valid3 = 1'b0;
    logic        cfg_ready3;
    logic [1:0]  cfg_chan3 = '0;
    logic [3:0]  cfg_div3 = '0;
    logic        cfg_mode3 = 1'b0;
    logic        cfg_err3;
    logic [2:0]  clk_div3;
    logic [2:0]  tick3;

    int n_cmp = 0;
    int n_err = 0;
    int n;

    always #5 clk = ~clk;

    // Main DUT uses a short default divisor so default-period checks stay cheap.
    clk_divider_multi #(.CHANNELS(4), .WIDTH(17), .DEFAULT_DIV(20)) u_dut (
        .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_chan(cfg_chan), .cfg_div(cfg_div), .cfg_mode(cfg_mode), .cfg_err(cfg_err),
        .clk_div(clk_div), .tick(tick)
    );

    // Three channels leave channel index 3 encodable but out of range.
    clk_divider_multi #(.CHANNELS(3), .WIDTH(4), .DEFAULT_DIV(5)) u_dut3 (
        .clk(clk), .rst(rst), .en(en3), .cfg_valid(cfg_valid3), .cfg_ready(cfg_ready3),
        .cfg_chan(cfg_chan3), .cfg_div(cfg_div3), .cfg_mode(cfg_mode3), .cfg_err(cfg_err3),
        .clk_div(clk_div3), .tick(tick3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Edges until tick[ch] is seen high; -1 when the budget runs out.
    task automatic wait_tick(input int ch, input int maxc, output int cnt);
        cnt = -1;
        for (int k = 1; k <= maxc; k++) begin
            step();
            if (tick[ch] === 1'b1) begin
                cnt = k;
                break;
            end
        end
    endtask

    task automatic cfg_write(input logic [1:0] ch, input logic [16:0] d, input logic m);
        cfg_chan  = ch;
        cfg_div   = d;
        cfg_mode  = m;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++; if (clk_div !== 4'b0) begin n_err++; $display("FAIL reset_clk_div: got %b want 0000", clk_div); end
        n_cmp++; if (tick !== 4'b0) begin n_err++; $display("FAIL reset_tick: got %b want 0000", tick); end
        n_cmp++; if (cfg_err !== 1'b0) begin n_err++; $display("FAIL reset_cfg_err: got %b want 0", cfg_err); end
        n_cmp++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL reset_cfg_ready: got %b want 1", cfg_ready); end
    endtask

    task automatic test_default();
        rst = 1'b1;
        en  = 4'b0001;
        wait_tick(0, 100, n);
        n_cmp++; if (n !== 20) begin n_err++; $display("FAIL default_first_tc: got %0d want 20", n); end
        n_cmp++; if (clk_div[0] !== 1'b1) begin n_err++; $display("FAIL default_toggle_hi: got %b want 1", clk_div[0]); end
        n_cmp++; if (clk_div[3:1] !== 3'b0 || tick[3:1] !== 3'b0) begin n_err++; $display("FAIL default_others: got %b/%b want 000/000", clk_div[3:1], tick[3:1]); end
        wait_tick(0, 100, n);
        n_cmp++; if (n !== 20) begin n_err++; $display("FAIL default_period: got %0d want 20", n); end
        n_cmp++; if (clk_div[0] !== 1'b0) begin n_err++; $display("FAIL default_toggle_lo: got %b want 0", clk_div[0]); end
        en = 4'b0000;
        step();
        n_cmp++; if (clk_div !== 4'b0 || tick !== 4'b0) begin n_err++; $display("FAIL disable_outputs: got %b/%b want 0000/0000", clk_div, tick); end
    endtask

    task automatic test_cfg_disabled();
        cfg_chan = 2'd1;
        n_cmp++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL dis_ready_before: got %b want 1", cfg_ready); end
        cfg_write(2'd1, 17'd3, 1'b1);
        n_cmp++; if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL dis_pending_set: ready got %b want 0", cfg_ready); end
        step();
        n_cmp++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL dis_pending_clear: ready got %b want 1", cfg_ready); end
        en = 4'b0010;
        wait_tick(1, 50, n);
        n_cmp++; if (n !== 3) begin n_err++; $display("FAIL pulse_first: got %0d want 3", n); end
        n_cmp++; if (clk_div[1] !== 1'b1) begin n_err++; $display("FAIL pulse_clk_div_hi: got %b want 1", clk_div[1]); end
        wait_tick(1, 50, n);
        n_cmp++; if (n !== 3) begin n_err++; $display("FAIL pulse_period: got %0d want 3", n); end
        step();
        n_cmp++; if (clk_div[1] !== 1'b0 || tick[1] !== 1'b0) begin n_err++; $display("FAIL pulse_width: got %b/%b want 0/0", clk_div[1], tick[1]); end
        en = 4'b0000;
        step();
    endtask

    task automatic test_reprogram();
        cfg_write(2'd0, 17'd5, 1'b0);
        step();
        en = 4'b0001;
        wait_tick(0, 50, n);
        n_cmp++; if (n !== 5) begin n_err++; $display("FAIL d5_first: got %0d want 5", n); end
        step();
        step();
        cfg_write(2'd0, 17'd2, 1'b0);
        n_cmp++; if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL midcount_ready: got %b want 0", cfg_ready); end
        wait_tick(0, 50, n);
        n_cmp++; if (n !== 2) begin n_err++; $display("FAIL apply_at_tc: got %0d want 2", n); end
        n_cmp++; if (clk_div[0] !== 1'b0 || cfg_ready !== 1'b1) begin n_err++; $display("FAIL apply_state: clk_div/ready got %b/%b want 0/1", clk_div[0], cfg_ready); end
        wait_tick(0, 50, n);
        n_cmp++; if (n !== 2 || clk_div[0] !== 1'b1) begin n_err++; $display("FAIL d2_rise: got %0d/%b want 2/1", n, clk_div[0]); end
        wait_tick(0, 50, n);
        n_cmp++; if (n !== 2 || clk_div[0] !== 1'b0) begin n_err++; $display("FAIL d2_fall: got %0d/%b want 2/0", n, clk_div[0]); end
    endtask

    task automatic test_cfg_err();
        cfg_chan  = 2'd0;
        cfg_div   = 17'd0;
        cfg_valid = 1'b1;
        n_cmp++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL zero_ready: got %b want 1", cfg_ready); end
        step();
        cfg_valid = 1'b0;
        n_cmp++; if (cfg_err !== 1'b1) begin n_err++; $display("FAIL zero_err: got %b want 1", cfg_err); end
        n_cmp++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL zero_no_pending: ready got %b want 1", cfg_ready); end
        step();
        n_cmp++; if (cfg_err !== 1'b0) begin n_err++; $display("FAIL zero_err_width: got %b want 0", cfg_err); end
        wait_tick(0, 50, n);
        wait_tick(0, 50, n);
        n_cmp++; if (n !== 2) begin n_err++; $display("FAIL zero_timing: got %0d want 2", n); end
        en = 4'b0000;
        cfg_chan3  = 2'd3;
        cfg_div3   = 4'd4;
        cfg_valid3 = 1'b1;
        n_cmp++; if (cfg_ready3 !== 1'b1) begin n_err++; $display("FAIL range_ready: got %b want 1", cfg_ready3); end
        step();
        cfg_valid3 = 1'b0;
        n_cmp++; if (cfg_err3 !== 1'b1) begin n_err++; $display("FAIL range_err: got %b want 1", cfg_err3); end
        step();
        n_cmp++; if (cfg_err3 !== 1'b0) begin n_err++; $display("FAIL range_err_width: got %b want 0", cfg_err3); end
        cfg_chan3 = 2'd0;
        n_cmp++; if (cfg_ready3 !== 1'b1) begin n_err++; $display("FAIL range_no_pending: ready got %b want 1", cfg_ready3); end
    endtask

    task automatic test_tc_edge();
        cfg_write(2'd2, 17'd4, 1'b0);
        step();
        en = 4'b0100;
        wait_tick(2, 50, n);
        n_cmp++; if (n !== 4) begin n_err++; $display("FAIL d4_first: got %0d want 4", n); end
        step();
        step();
        step();
        cfg_write(2'd2, 17'd6, 1'b0);
        n_cmp++; if (tick[2] !== 1'b1) begin n_err++; $display("FAIL edge_tick: got %b want 1", tick[2]); end
        n_cmp++; if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL edge_pending: ready got %b want 0", cfg_ready); end
        wait_tick(2, 50, n);
        n_cmp++; if (n !== 4) begin n_err++; $display("FAIL edge_last_d4: got %0d want 4", n); end
        n_cmp++; if (cfg_ready !== 1'b1 || clk_div[2] !== 1'b0) begin n_err++; $display("FAIL edge_apply: ready/clk_div got %b/%b want 1/0", cfg_ready, clk_div[2]); end
        wait_tick(2, 50, n);
        n_cmp++; if (n !== 6 || clk_div[2] !== 1'b1) begin n_err++; $display("FAIL d6_rise: got %0d/%b want 6/1", n, clk_div[2]); end
        wait_tick(2, 50, n);
        n_cmp++; if (n !== 6 || clk_div[2] !== 1'b0) begin n_err++; $display("FAIL d6_fall: got %0d/%b want 6/0", n, clk_div[2]); end
    endtask

    task automatic test_reset_pending();
        wait_tick(2, 50, n);
        n_cmp++; if (n !== 6 || clk_div[2] !== 1'b1) begin n_err++; $display("FAIL pre_reset: got %0d/%b want 6/1", n, clk_div[2]); end
        step();
        cfg_write(2'd2, 17'd3, 1'b0);
        n_cmp++; if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL pre_reset_pending: ready got %b want 0", cfg_ready); end
        rst = 1'b0;
        #1;
        n_cmp++; if (clk_div !== 4'b0 || tick !== 4'b0) begin n_err++; $display("FAIL async_reset: got %b/%b want 0000/0000", clk_div, tick); end
        n_cmp++; if (cfg_ready !== 1'b1 || cfg_err !== 1'b0) begin n_err++; $display("FAIL async_reset_cfg: ready/err got %b/%b want 1/0", cfg_ready, cfg_err); end
        step();
        rst = 1'b1;
        en  = 4'b0101;
        wait_tick(0, 100, n);
        n_cmp++; if (n !== 20) begin n_err++; $display("FAIL post_reset_div: got %0d want 20", n); end
        n_cmp++; if (tick[2] !== 1'b1 || clk_div[2] !== 1'b1) begin n_err++; $display("FAIL post_reset_lost_cfg: tick/clk_div got %b/%b want 1/1", tick[2], clk_div[2]); end
        en = 4'b0000;
    endtask

    initial begin
        step();
        step();
        test_reset();
        test_default();
        test_cfg_disabled();
        test_reprogram();
        test_cfg_err();
        test_tc_edge();
        test_reset_pending();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
